// File: rtl/twpm_wb_pkg.sv
// Shared definitions for the TPM Wishbone mailbox: register offsets, STATUS bit positions,
// the bus FSM state type and the default read pattern for unmapped register offsets.
package twpm_wb_pkg;

    // Register offsets (byte addresses, word aligned)
    localparam logic [7:0] RegStatus   = 8'h00;
    localparam logic [7:0] RegOpType   = 8'h04;
    localparam logic [7:0] RegLocality = 8'h08;
    localparam logic [7:0] RegBufSize  = 8'h0C;
    localparam logic [7:0] RegComplete = 8'h40;
    localparam logic [7:0] RegIrqStat  = 8'h44;

    // STATUS register bit positions
    localparam int unsigned StatExecBit     = 0;
    localparam int unsigned StatAbortBit    = 1;
    localparam int unsigned StatCompleteBit = 2;
    localparam int unsigned StatIrqBit      = 3;

    localparam logic [31:0] DefaultRd = 32'hBADFABAC;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StResp
    } wb_state_e;

endpackage

// File: rtl/twpm_wb_mailbox_if.sv
// Wishbone-B4 classic bus bundle between the CPU (master) and the mailbox (slave).
//   wb_adr_i/wb_dat_i/wb_we_i/wb_sel_i/wb_stb_i/wb_cyc_i : master -> slave
//   wb_dat_o/wb_ack_o/wb_err_o                            : slave -> master
interface twpm_wb_mailbox_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/twpm_sync_pulse.sv
// Multi-flop synchroniser with rising-edge detect.
//   clk_i   : destination clock
//   rstn_i  : async active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised level
//   rise_o  : one-cycle pulse on a rising edge of q_o
module twpm_sync_pulse #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/twpm_wb_mailbox.sv
// Wishbone slave between the CPU and the TPM command mailbox.
// Serves the mailbox registers, gives the CPU access to the shared buffer RAM only while it
// owns the buffer (synchronised exec), and generates the completion pulse.
// Optional feature macro: TWPM_WB_IRQ_EN (interrupt on exec/abort rising edges, IRQ_STAT W1C).
//   clk_i, rstn_i          : clock, async active-low reset
//   wb                     : Wishbone slave port (interface)
//   exec_i, abort_i        : LPC-domain async flags
//   op_type_i, locality_i  : command attributes, stable while exec is high
//   buf_len_i              : command length in bytes
//   complete_o             : completion pulse to the regs module
//   buf_own_o              : CPU owns the buffer RAM
//   ram_addr_o/wd_o/wen_o  : buffer RAM word address, write data, byte write enables
//   ram_rd_i               : buffer RAM read data (1-cycle latency)
//   irq_o                  : interrupt (0 unless TWPM_WB_IRQ_EN)
module twpm_wb_mailbox
    import twpm_wb_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 11,
    parameter int unsigned WB_ADDR_WIDTH  = 17,
    parameter int unsigned CPL_PULSE_W    = 20,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [31:0] DEFAULT_RD     = DefaultRd
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    twpm_wb_mailbox_if.slave          wb,
    input  logic                      exec_i,
    input  logic                      abort_i,
    input  logic [3:0]                op_type_i,
    input  logic [3:0]                locality_i,
    input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
    output logic                      complete_o,
    output logic                      buf_own_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]               ram_wd_o,
    output logic [3:0]                ram_wen_o,
    input  logic [31:0]               ram_rd_i,
    output logic                      irq_o
);

    localparam int unsigned PageW = WB_ADDR_WIDTH - RAM_ADDR_WIDTH;

    wb_state_e   state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        active_q;
    logic        exec_s, exec_rise, abort_s, abort_rise;
    logic        irq_pend;
    logic        req, ram_hit, reg_page;
    logic        cpl_wr, irq_clr;
    logic [31:0] status, reg_rdata;

    twpm_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync_exec (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (exec_i),
        .q_o    (exec_s),
        .rise_o (exec_rise)
    );

    twpm_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync_abort (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (abort_i),
        .q_o    (abort_s),
        .rise_o (abort_rise)
    );

    assign buf_own_o = exec_s;

    // Address decode: RAM window is the page at 1<<RAM_ADDR_WIDTH; registers live in the
    // low 256 bytes of page 0.
    assign ram_hit  = wb.wb_adr_i[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH] == PageW'(1);
    assign reg_page = wb.wb_adr_i[WB_ADDR_WIDTH-1:8] == '0;

    logic unused_adr;
    assign unused_adr = ^{wb.wb_adr_i[31:WB_ADDR_WIDTH], wb.wb_adr_i[1:0]};

    assign ram_addr_o = wb.wb_adr_i[RAM_ADDR_WIDTH-1:2];
    assign ram_wd_o   = wb.wb_dat_i;

    // Blocks acceptance while reset is asserted so no RAM strobe can leak out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) active_q <= 1'b0;
        else         active_q <= 1'b1;
    end

    assign req = active_q & wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;

    always_comb begin
        status                  = '0;
        status[StatExecBit]     = exec_s;
        status[StatAbortBit]    = abort_s;
        status[StatCompleteBit] = complete_o;
        status[StatIrqBit]      = irq_pend;
    end

    always_comb begin
        reg_rdata = DEFAULT_RD;
        if (reg_page) begin
            case (wb.wb_adr_i[7:2])
                RegStatus[7:2]:   reg_rdata = status;
                RegOpType[7:2]:   reg_rdata = {28'b0, op_type_i};
                RegLocality[7:2]: reg_rdata = {28'b0, locality_i};
                RegBufSize[7:2]:  reg_rdata = 32'(buf_len_i);
                RegComplete[7:2]: reg_rdata = '0;
`ifdef TWPM_WB_IRQ_EN
                RegIrqStat[7:2]:  reg_rdata = {31'b0, irq_pend};
`endif
                default:          reg_rdata = DEFAULT_RD;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        cpl_wr    = 1'b0;
        irq_clr   = 1'b0;
        ram_wen_o = '0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StResp;
                    if (ram_hit) begin
                        if (!buf_own_o) begin
                            err_d = 1'b1;
                        end else if (wb.wb_we_i) begin
                            ram_wen_o = wb.wb_sel_i;
                            ack_d     = 1'b1;
                        end else begin
                            state_d = StRdWait;
                        end
                    end else begin
                        ack_d = 1'b1;
                        if (wb.wb_we_i) begin
                            cpl_wr  = reg_page && (wb.wb_adr_i[7:2] == RegComplete[7:2]);
                            irq_clr = reg_page && (wb.wb_adr_i[7:2] == RegIrqStat[7:2])
                                      && wb.wb_sel_i[0] && wb.wb_dat_i[0];
                        end else begin
                            dat_d = reg_rdata;
                        end
                    end
                end
            end
            StRdWait: begin
                if (!wb.wb_cyc_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StResp;
                    // Ownership lost during the wait: the data may already be stale.
                    if (exec_s) begin
                        ack_d = 1'b1;
                        dat_d = ram_rd_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cpl_wr && cnt_q == 8'd0) cnt_d = 8'(CPL_PULSE_W);
        else if (cnt_q != 8'd0)      cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign complete_o  = cnt_q != 8'd0;

`ifdef TWPM_WB_IRQ_EN
    logic irq_pend_q;

    // A new edge in the same cycle as the clear must not be lost.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                       irq_pend_q <= 1'b0;
        else if (exec_rise || abort_rise)  irq_pend_q <= 1'b1;
        else if (irq_clr)                  irq_pend_q <= 1'b0;
    end

    assign irq_pend = irq_pend_q;
    assign irq_o    = irq_pend_q;
`else
    logic unused_irq;
    assign unused_irq = exec_rise ^ abort_rise ^ irq_clr;
    assign irq_pend   = 1'b0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_twpm_wb_mailbox.sv
// Directed testbench for twpm_wb_mailbox: register reads, RAM access under ownership,
// completion pulse, cyc drop, interrupt (when built with TWPM_WB_IRQ_EN) and async reset.
module tb_twpm_wb_mailbox;

`ifdef TWPM_WB_IRQ_EN
    localparam bit IrqBuild = 1'b1;
`else
    localparam bit IrqBuild = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        exec_i, abort_i;
    logic [3:0]  op_type_i, locality_i;
    logic [10:0] buf_len_i;
    logic        complete_o, buf_own_o, irq_o;
    logic [8:0]  ram_addr_o;
    logic [31:0] ram_wd_o, ram_rd_i;
    logic [3:0]  ram_wen_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cycles = 0;
    int cpl_cycles = 0;

    twpm_wb_mailbox_if bus ();

    twpm_wb_mailbox dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .wb         (bus),
        .exec_i     (exec_i),
        .abort_i    (abort_i),
        .op_type_i  (op_type_i),
        .locality_i (locality_i),
        .buf_len_i  (buf_len_i),
        .complete_o (complete_o),
        .buf_own_o  (buf_own_o),
        .ram_addr_o (ram_addr_o),
        .ram_wd_o   (ram_wd_o),
        .ram_wen_o  (ram_wen_o),
        .ram_rd_i   (ram_rd_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    // Sync-read RAM stand-in: data is a recognisable function of the word address.
    always @(posedge clk) ram_rd_i <= 32'hD00D_0000 | 32'(ram_addr_o);

    always @(negedge clk) begin
        if (ram_wen_o != 4'b0) wen_cycles <= wen_cycles + 1;
        if (complete_o)        cpl_cycles <= cpl_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer. lat = negedges after the accept edge until ack/err (0 = timeout).
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output logic ack,
                           output logic err, output logic [31:0] rdat,
                           output logic [3:0] wen_acc, output logic [31:0] wd_acc);
        @(posedge clk); #2;
        bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_we_i = we; bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
        @(negedge clk);
        wen_acc = ram_wen_o;
        wd_acc  = ram_wd_o;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o || bus.wb_err_o) begin
                lat = i; ack = bus.wb_ack_o; err = bus.wb_err_o; rdat = bus.wb_dat_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_sel_i = '0;
        #1;
    endtask

    initial begin
        int          lat;
        logic        ack, err;
        logic [31:0] rdat, wd;
        logic [3:0]  wen;
        int          snap;
        logic        seen;

        rstn = 1'b0; exec_i = 1'b0; abort_i = 1'b0;
        op_type_i = 4'h5; locality_i = 4'h2; buf_len_i = 11'h123;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0; bus.wb_sel_i = '0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_err", 32'(bus.wb_err_o), 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        check("rst_cpl", 32'(complete_o), 32'd0);
        check("rst_own", 32'(buf_own_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: BUF_SIZE read
        wb_xfer(32'h0C, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("bufsz_lat", 32'(lat), 32'd1);
        check("bufsz_ack", 32'(ack), 32'd1);
        check("bufsz_dat", rdat, 32'h123);
        wb_xfer(32'h04, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("optype_dat", rdat, 32'h5);

        // 2: ownership and RAM access
        @(posedge clk); #2; exec_i = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("own_set", 32'(buf_own_o), 32'd1);
        wb_xfer(32'h00, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("status_exec", rdat, IrqBuild ? 32'h9 : 32'h1);
        snap = wen_cycles;
        wb_xfer(32'h800, 1'b1, 32'h0000AB00, 4'b0010, lat, ack, err, rdat, wen, wd);
        check("ramwr_wen", 32'(wen), 32'b0010);
        check("ramwr_wd", wd, 32'h0000AB00);
        check("ramwr_ack", 32'(ack), 32'd1);
        check("ramwr_lat", 32'(lat), 32'd1);
        check("ramwr_pulses", 32'(wen_cycles - snap), 32'd1);
        wb_xfer(32'h800, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("ramrd_lat", 32'(lat), 32'd2);
        check("ramrd_ack", 32'(ack), 32'd1);
        check("ramrd_dat", rdat, 32'hD00D0000);

        // 3: access without ownership
        @(posedge clk); #2; exec_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("own_clr", 32'(buf_own_o), 32'd0);
        snap = wen_cycles;
        wb_xfer(32'h804, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("noown_rd_err", 32'(err), 32'd1);
        check("noown_rd_ack", 32'(ack), 32'd0);
        wb_xfer(32'h804, 1'b1, 32'h12345678, 4'hF, lat, ack, err, rdat, wen, wd);
        check("noown_wr_err", 32'(err), 32'd1);
        check("noown_wr_wen", 32'(wen), 32'd0);
        check("noown_pulses", 32'(wen_cycles - snap), 32'd0);

        // 4: completion pulse, second write ignored
        snap = cpl_cycles;
        wb_xfer(32'h40, 1'b1, 32'h1, 4'hF, lat, ack, err, rdat, wen, wd);
        check("cpl_ack", 32'(ack), 32'd1);
        check("cpl_high", 32'(complete_o), 32'd1);
        wb_xfer(32'h00, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("status_cpl", rdat, IrqBuild ? 32'hC : 32'h4);
        repeat (3) @(posedge clk);
        wb_xfer(32'h40, 1'b1, 32'h1, 4'hF, lat, ack, err, rdat, wen, wd);
        check("cpl2_ack", 32'(ack), 32'd1);
        repeat (40) @(posedge clk); #1;
        check("cpl_cycles", 32'(cpl_cycles - snap), 32'd20);
        check("cpl_done", 32'(complete_o), 32'd0);

        // 5: unmapped read, abort status, cyc drop, ownership loss during read
        wb_xfer(32'h10, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("unmapped_dat", rdat, 32'hBADFABAC);
        check("unmapped_ack", 32'(ack), 32'd1);
        @(posedge clk); #2; abort_i = 1'b1;
        repeat (4) @(posedge clk);
        wb_xfer(32'h00, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("status_abort", rdat, IrqBuild ? 32'hA : 32'h2);
        abort_i = 1'b0; exec_i = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        bus.wb_adr_i = 32'h808; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #2;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.wb_ack_o | bus.wb_err_o;
        end
        check("cycdrop_noresp", 32'(seen), 32'd0);
        wb_xfer(32'h808, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("after_drop_lat", 32'(lat), 32'd2);
        check("after_drop_dat", rdat, 32'hD00D0002);
        @(posedge clk); #2; exec_i = 1'b0;
        wb_xfer(32'h80C, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("ownloss_err", 32'(err), 32'd1);
        check("ownloss_ack", 32'(ack), 32'd0);
        check("ownloss_lat", 32'(lat), 32'd2);

        // 6: interrupt and reset mid-read
        repeat (3) @(posedge clk);
        wb_xfer(32'h44, 1'b1, 32'h1, 4'hF, lat, ack, err, rdat, wen, wd);
        check("irqclr0_ack", 32'(ack), 32'd1);
        check("irq_cleared0", 32'(irq_o), 32'd0);
        @(posedge clk); #2; exec_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("irq_on_exec", 32'(irq_o), 32'(IrqBuild));
        wb_xfer(32'h44, 1'b1, 32'h1, 4'hF, lat, ack, err, rdat, wen, wd);
        check("irq_cleared", 32'(irq_o), 32'd0);
        wb_xfer(32'h808, 1'b0, '0, 4'hF, lat, ack, err, rdat, wen, wd);
        check("pre_rst_dat", rdat, 32'hD00D0002);
        @(posedge clk); #2;
        bus.wb_adr_i = 32'h800; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
        check("midrst_err", 32'(bus.wb_err_o), 32'd0);
        check("midrst_dat", bus.wb_dat_o, 32'd0);
        check("midrst_own", 32'(buf_own_o), 32'd0);
        check("midrst_wen", 32'(ram_wen_o), 32'd0);
        check("midrst_cpl", 32'(complete_o), 32'd0);
        check("midrst_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        check("midrst_ack2", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
